instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Upstream boot stage of Simple_Single_CPU: accepts a program as a byte stream and writes it word by word into the CPU instruction memory, replacing file-based preload.
- Holds the CPU in reset while loading; releases it once a terminator word is written.
- A word of 32'h00000000 marks end of program; it is also written to memory, so the CPU's end-of-program detection still sees the zero word.

Parameters:
- IM_DEPTH, 32, number of 32-bit words in instruction memory.
- IM_AW, $clog2(IM_DEPTH), width of the word index.
- TIMEOUT_CYC, 1024, maximum idle cycles between bytes while in RECV.

Ports:
- clk_i  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  pulse: begin a new load.
- byte_i  in  8  stream data byte.
- byte_valid_i  in  1  byte_i valid.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- im_we_o  out  1  instruction-memory write strobe, one cycle per word.
- im_addr_o  out  IM_AW  word index (byte address = index<<2).
- im_wdata_o  out  32  word to write.
- cpu_rst_n_o  out  1  active-low reset to the CPU.
- busy_o  out  1  load in progress.
- done_o  out  1  load finished, CPU running.
- err_o  out  1  load aborted (sticky until start_i or rst_n).
- word_cnt_o  out  IM_AW+1  words written in the current load.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, byte_ready_o=0, im_we_o=0, im_addr_o=0, im_wdata_o=0, cpu_rst_n_o=0, busy_o=0, done_o=0, err_o=0, word_cnt_o=0, byte lane=0, timeout counter=0.
- States: IDLE, RECV, WRITE, RUN, ERR.
- IDLE: cpu_rst_n_o=0.
  - start_i -> RECV.
  - Clear word_cnt, lane, address and err.
- RECV: byte_ready_o=1, busy_o=1.
  - A byte transfers when byte_valid_i && byte_ready_o.
  - Bytes are assembled little-endian: lane 0 -> [7:0], up to lane 3 -> [31:24].
  - After the lane-3 transfer, the assembled word is registered -> WRITE.
- WRITE: byte_ready_o=0.
  - Assert im_we_o for exactly one cycle with im_addr_o=word_cnt and im_wdata_o=word.
  - Then increment word_cnt.
  - If word==0 -> RUN.
  - Else if word_cnt reaches IM_DEPTH -> ERR (no terminator fit).
  - Else -> RECV.
- Latency: last byte accepted at cycle N -> im_we_o at N+1. Terminator write at N+1 -> cpu_rst_n_o=1 and done_o=1 at N+2.
- RUN: cpu_rst_n_o=1, done_o=1, byte_ready_o=0; bytes are ignored.
  - start_i -> drop cpu_rst_n_o the same edge and go to RECV (reload).
- ERR: err_o=1, cpu_rst_n_o=0, byte_ready_o=0. Only start_i or rst_n exits.
- Timeout:
  - In RECV, the counter increments each cycle with no transfer and clears on every transfer.
  - Reaching TIMEOUT_CYC -> ERR.
  - No timeout before the first byte of a load.
- start_i during RECV/WRITE: abort the current load, restart at address 0. Partially written words remain in memory.
- rst_n mid-load: all state returns to reset values immediately; the CPU is held in reset.
- Only the terminator test uses the full word; no other decoding of content.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the terminator write, the loader stays in RECV for one more 4-byte word. This word is not written to memory.
  - It is compared with the mod-2^32 sum of all written words, terminator included.
  - Equal -> RUN. Mismatch -> ERR.
  - An extra output chk_err_o (1 bit) flags the mismatch. It resets to 0 and clears on start_i.
  - The sum register is 32 bits and wraps.
- Undefined: go to RUN directly after the terminator; no sum logic, no chk_err_o port.

Decomposition:
- Shared package loader_pkg: state enum (IDLE/RECV/WRITE/RUN/ERR), TERM_WORD=32'h0, little-endian lane constants.
- One sub-module: byte_word_assembler (lane counter + 32-bit shift/assemble register, outputs word_valid pulse); the FSM, timeout and checksum stay in the top module.

Test Plan:
- Normal load: start_i, then bytes 20 00 01 01 | 00 00 00 00. Expect:
  - im_we_o at addr 0 with 0x01010020.
  - im_we_o at addr 1 with 0x00000000.
  - word_cnt_o=2; cpu_rst_n_o rises 1 cycle after the second write; done_o=1.
- Backpressure/gaps: valid toggled 1-0-1 with gaps of 5 cycles. Expect the same words, no lost or duplicated byte, and no timeout.
- Overflow: 32 nonzero words, no terminator. Expect 32 writes, then err_o=1, cpu_rst_n_o stays 0, byte_ready_o=0.
- Timeout: 2 bytes, then valid low for 1024 cycles. Expect err_o=1 and no im_we_o.
- Reload: while in RUN, pulse start_i. Expect:
  - cpu_rst_n_o=0 next cycle, word_cnt_o=0.
  - A new program is written from addr 0.
- LOADER_CHECKSUM_EN: words 0x00000005, 0x0 plus trailer 0x00000005 -> RUN. Trailer 0x00000006 -> err_o=1, chk_err_o=1.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, terminator word and byte-lane constants for the instruction-memory loader
package loader_pkg;

   typedef enum logic [2:0] {IDLE, RECV, WRITE, RUN, ERR} state_t;

   localparam logic [31:0] TERM_WORD  = 32'h0000_0000;
   localparam logic [1:0]  LANE_FIRST = 2'd0;
   localparam logic [1:0]  LANE_LAST  = 2'd3;

endpackage

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: gathers four little-endian bytes into a 32-bit word and flags the cycle the last byte arrives
module byte_word_assembler
   import loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        xfer_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [1:0]  lane_q;
   logic [23:0] acc_q;

   assign word_o       = {byte_i, acc_q};
   assign word_valid_o = xfer_i && (lane_q == LANE_LAST);

   // shift each accepted byte in from the top so lane 0 settles in bits [7:0]
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         lane_q <= LANE_FIRST;
         acc_q  <= '0;
      end else if (clr_i) begin
         lane_q <= LANE_FIRST;
         acc_q  <= '0;
      end else if (xfer_i) begin
         lane_q <= lane_q + 2'd1;
         acc_q  <= {byte_i, acc_q[23:8]};
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writes a byte-streamed program into instruction memory, holding the CPU in reset until the zero terminator is stored
// Optional macro LOADER_CHECKSUM_EN: expect one trailing word equal to the mod-2^32 sum of all written words; adds chk_err_o.
module instr_mem_loader
   import loader_pkg::*;
#(
   parameter int IM_DEPTH    = 32,
   parameter int IM_AW       = $clog2(IM_DEPTH),
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [7:0]       byte_i,
   input  logic             byte_valid_i,
   output logic             byte_ready_o,
   output logic             im_we_o,
   output logic [IM_AW-1:0] im_addr_o,
   output logic [31:0]      im_wdata_o,
   output logic             cpu_rst_n_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
`ifdef LOADER_CHECKSUM_EN
   output logic             chk_err_o,
`endif
   output logic [IM_AW:0]   word_cnt_o
);

   localparam int              TO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IM_AW:0]  LAST_CNT = (IM_AW+1)'(IM_DEPTH - 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

   state_t            state_q;
   logic              ready_q, we_q, cpu_rst_n_q, busy_q, done_q, err_q, seen_q;
   logic [IM_AW-1:0]  addr_q;
   logic [31:0]       wdata_q;
   logic [IM_AW:0]    cnt_q;
   logic [TO_W-1:0]   to_q;
   logic              xfer, word_valid;
   logic [31:0]       word;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]       sum_q;
   logic              chk_err_q, chk_ph_q;

   assign chk_err_o = chk_err_q;
`endif

   assign xfer         = byte_valid_i && ready_q;
   assign byte_ready_o = ready_q;
   assign im_we_o      = we_q;
   assign im_addr_o    = addr_q;
   assign im_wdata_o   = wdata_q;
   assign cpu_rst_n_o  = cpu_rst_n_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign word_cnt_o   = cnt_q;

   byte_word_assembler u_asm (
      .clk_i        (clk_i),
      .rst_n        (rst_n),
      .clr_i        (start_i),
      .xfer_i       (xfer),
      .byte_i       (byte_i),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   // load sequencer: start_i restarts from any state; outputs are registered alongside the state
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         to_q        <= '0;
         seen_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q       <= '0;
         chk_err_q   <= 1'b0;
         chk_ph_q    <= 1'b0;
`endif
      end else if (start_i) begin
         state_q     <= RECV;
         ready_q     <= 1'b1;
         we_q        <= 1'b0;
         addr_q      <= '0;
         cpu_rst_n_q <= 1'b0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         to_q        <= '0;
         seen_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q       <= '0;
         chk_err_q   <= 1'b0;
         chk_ph_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            RECV: begin
               if (word_valid) begin
                  to_q    <= '0;
                  seen_q  <= 1'b1;
                  ready_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  if (chk_ph_q) begin
                     busy_q <= 1'b0;
                     if (word == sum_q) begin
                        state_q     <= RUN;
                        cpu_rst_n_q <= 1'b1;
                        done_q      <= 1'b1;
                     end else begin
                        state_q   <= ERR;
                        err_q     <= 1'b1;
                        chk_err_q <= 1'b1;
                     end
                  end else begin
                     state_q <= WRITE;
                     we_q    <= 1'b1;
                     addr_q  <= cnt_q[IM_AW-1:0];
                     wdata_q <= word;
                  end
`else
                  state_q <= WRITE;
                  we_q    <= 1'b1;
                  addr_q  <= cnt_q[IM_AW-1:0];
                  wdata_q <= word;
`endif
               end else if (xfer) begin
                  to_q   <= '0;
                  seen_q <= 1'b1;
               end else if (seen_q) begin
                  if (to_q == TO_LAST) begin
                     state_q <= ERR;
                     err_q   <= 1'b1;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b0;
                  end else begin
                     to_q <= to_q + TO_W'(1);
                  end
               end
            end
            WRITE: begin
               we_q  <= 1'b0;
               cnt_q <= cnt_q + (IM_AW+1)'(1);
`ifdef LOADER_CHECKSUM_EN
               sum_q <= sum_q + wdata_q;
`endif
               if (wdata_q == TERM_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                  state_q  <= RECV;
                  ready_q  <= 1'b1;
                  chk_ph_q <= 1'b1;
`else
                  state_q     <= RUN;
                  busy_q      <= 1'b0;
                  cpu_rst_n_q <= 1'b1;
                  done_q      <= 1'b1;
`endif
               end else if (cnt_q == LAST_CNT) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= RECV;
                  ready_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed scenarios for the instruction-memory loader with hand-computed expectations
module tb_instr_mem_loader;

   logic        clk_i = 1'b0, rst_n = 1'b0, start_i = 1'b0, byte_valid_i = 1'b0;
   logic [7:0]  byte_i = 8'h00;
   logic        byte_ready_o, im_we_o, cpu_rst_n_o, busy_o, done_o, err_o;
   logic [4:0]  im_addr_o;
   logic [31:0] im_wdata_o;
   logic [5:0]  word_cnt_o;
`ifdef LOADER_CHECKSUM_EN
   logic        chk_err_o;
`endif
   int          total = 0, bad = 0;
   logic [4:0]  wa[$];
   logic [31:0] wd[$];

   instr_mem_loader dut (
      .clk_i        (clk_i),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .im_we_o      (im_we_o),
      .im_addr_o    (im_addr_o),
      .im_wdata_o   (im_wdata_o),
      .cpu_rst_n_o  (cpu_rst_n_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
`ifdef LOADER_CHECKSUM_EN
      .chk_err_o    (chk_err_o),
`endif
      .word_cnt_o   (word_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (im_we_o === 1'b1) begin
         wa.push_back(im_addr_o);
         wd.push_back(im_wdata_o);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      byte_i = b;
      byte_valid_i = 1'b1;
      while (byte_ready_o !== 1'b1 && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      @(negedge clk_i);
      byte_valid_i = 1'b0;
      if (n >= 20) begin
         total++;
         bad++;
         $display("FAIL send_byte: byte_ready_o=%b after 20 cycles, want 1", byte_ready_o);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic gapped_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8]);
         repeat (5) @(negedge clk_i);
      end
   endtask

   task automatic term_and_run(input logic [31:0] sum);
      send_word(32'h0);
`ifdef LOADER_CHECKSUM_EN
      send_word(sum);
`else
      if (sum === 32'hx) $display("unexpected sum");
      @(negedge clk_i);
`endif
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk_i);
      total++;
      if ({byte_ready_o, im_we_o, cpu_rst_n_o, busy_o, done_o, err_o} !== 6'b0) begin
         bad++;
         $display("FAIL reset_flags: got rdy/we/cpu/busy/done/err=%b, want 000000",
                  {byte_ready_o, im_we_o, cpu_rst_n_o, busy_o, done_o, err_o});
      end
      total++;
      if ({im_addr_o, im_wdata_o, word_cnt_o} !== 43'h0) begin
         bad++;
         $display("FAIL reset_data: got addr=%0d data=%h cnt=%0d, want 0 0 0", im_addr_o, im_wdata_o, word_cnt_o);
      end
      rst_n = 1'b1;
      byte_valid_i = 1'b1;
      repeat (3) @(negedge clk_i);
      byte_valid_i = 1'b0;
      total++;
      if ({byte_ready_o, busy_o, cpu_rst_n_o, wa.size() == 0} !== 4'b0001) begin
         bad++;
         $display("FAIL idle_hold: got rdy=%b busy=%b cpu=%b writes=%0d, want 0 0 0 0",
                  byte_ready_o, busy_o, cpu_rst_n_o, wa.size());
      end
   endtask

   task automatic test_normal();
      clear_log();
      pulse_start();
      total++;
      if ({busy_o, byte_ready_o, cpu_rst_n_o, word_cnt_o} !== {3'b110, 6'd0}) begin
         bad++;
         $display("FAIL normal_start: got busy=%b rdy=%b cpu=%b cnt=%0d, want 1 1 0 0",
                  busy_o, byte_ready_o, cpu_rst_n_o, word_cnt_o);
      end
      send_word(32'h0101_0020);
      total++;
      if ({im_we_o, im_addr_o, im_wdata_o} !== {1'b1, 5'd0, 32'h0101_0020}) begin
         bad++;
         $display("FAIL normal_w0: got we=%b addr=%0d data=%h, want 1 0 01010020", im_we_o, im_addr_o, im_wdata_o);
      end
      send_word(32'h0);
      total++;
      if ({im_we_o, im_addr_o, im_wdata_o, cpu_rst_n_o} !== {1'b1, 5'd1, 32'h0, 1'b0}) begin
         bad++;
         $display("FAIL normal_term: got we=%b addr=%0d data=%h cpu=%b, want 1 1 00000000 0",
                  im_we_o, im_addr_o, im_wdata_o, cpu_rst_n_o);
      end
`ifdef LOADER_CHECKSUM_EN
      send_word(32'h0101_0020);
`else
      @(negedge clk_i);
`endif
      total++;
      if ({cpu_rst_n_o, done_o, busy_o, byte_ready_o, err_o, word_cnt_o} !== {5'b11000, 6'd2}) begin
         bad++;
         $display("FAIL normal_run: got cpu=%b done=%b busy=%b rdy=%b err=%b cnt=%0d, want 1 1 0 0 0 2",
                  cpu_rst_n_o, done_o, busy_o, byte_ready_o, err_o, word_cnt_o);
      end
      total++;
      if (wa.size() != 2 || wa[0] !== 5'd0 || wd[0] !== 32'h0101_0020 || wa[1] !== 5'd1 || wd[1] !== 32'h0) begin
         bad++;
         $display("FAIL normal_log: got %0d writes, want 2 writes 0:01010020 1:00000000", wa.size());
      end
   endtask

   task automatic test_run_ignore();
      byte_i = 8'h55;
      byte_valid_i = 1'b1;
      repeat (8) @(negedge clk_i);
      byte_valid_i = 1'b0;
      total++;
      if ({wa.size() == 2, done_o, byte_ready_o, word_cnt_o} !== {3'b110, 6'd2}) begin
         bad++;
         $display("FAIL run_ignore: got writes=%0d done=%b rdy=%b cnt=%0d, want 2 1 0 2",
                  wa.size(), done_o, byte_ready_o, word_cnt_o);
      end
   endtask

   task automatic test_reload();
      clear_log();
      pulse_start();
      total++;
      if ({cpu_rst_n_o, done_o, busy_o, word_cnt_o} !== {3'b001, 6'd0}) begin
         bad++;
         $display("FAIL reload_start: got cpu=%b done=%b busy=%b cnt=%0d, want 0 0 1 0",
                  cpu_rst_n_o, done_o, busy_o, word_cnt_o);
      end
      send_word(32'hDEAD_BEEF);
      term_and_run(32'hDEAD_BEEF);
      total++;
      if (wa.size() != 2 || wa[0] !== 5'd0 || wd[0] !== 32'hDEAD_BEEF || wa[1] !== 5'd1 || wd[1] !== 32'h0
          || done_o !== 1'b1) begin
         bad++;
         $display("FAIL reload_log: got %0d writes done=%b, want 2 writes 0:deadbeef 1:00000000 done=1",
                  wa.size(), done_o);
      end
   endtask

   task automatic test_gaps();
      clear_log();
      pulse_start();
      gapped_word(32'h1234_5678);
      gapped_word(32'h0);
`ifdef LOADER_CHECKSUM_EN
      gapped_word(32'h1234_5678);
`endif
      total++;
      if ({err_o, done_o, word_cnt_o} !== {2'b01, 6'd2}) begin
         bad++;
         $display("FAIL gaps_state: got err=%b done=%b cnt=%0d, want 0 1 2", err_o, done_o, word_cnt_o);
      end
      total++;
      if (wa.size() != 2 || wa[0] !== 5'd0 || wd[0] !== 32'h1234_5678 || wa[1] !== 5'd1 || wd[1] !== 32'h0) begin
         bad++;
         $display("FAIL gaps_log: got %0d writes first=%h, want 2 writes 0:12345678 1:00000000",
                  wa.size(), (wd.size() > 0) ? wd[0] : 32'hx);
      end
   endtask

   task automatic test_overflow();
      int miss = 0;
      clear_log();
      pulse_start();
      for (int i = 0; i < 32; i++) send_word(32'h1000_0000 | i);
      @(negedge clk_i);
      total++;
      if ({err_o, cpu_rst_n_o, byte_ready_o, busy_o, done_o, word_cnt_o} !== {5'b10000, 6'd32}) begin
         bad++;
         $display("FAIL overflow_state: got err=%b cpu=%b rdy=%b busy=%b done=%b cnt=%0d, want 1 0 0 0 0 32",
                  err_o, cpu_rst_n_o, byte_ready_o, busy_o, done_o, word_cnt_o);
      end
      for (int i = 0; i < wa.size(); i++) if (wa[i] !== 5'(i) || wd[i] !== (32'h1000_0000 | i)) miss++;
      total++;
      if (wa.size() != 32 || miss != 0) begin
         bad++;
         $display("FAIL overflow_log: got %0d writes with %0d wrong, want 32 writes 0 wrong", wa.size(), miss);
      end
   endtask

   task automatic test_abort();
      clear_log();
      pulse_start();
      total++;
      if ({err_o, busy_o} !== 2'b01) begin
         bad++;
         $display("FAIL abort_err_clear: got err=%b busy=%b, want 0 1", err_o, busy_o);
      end
      send_word(32'hAAAA_5555);
      send_byte(8'h11);
      send_byte(8'h22);
      pulse_start();
      total++;
      if ({word_cnt_o, busy_o} !== {6'd0, 1'b1}) begin
         bad++;
         $display("FAIL abort_restart: got cnt=%0d busy=%b, want 0 1", word_cnt_o, busy_o);
      end
      send_word(32'hCAFE_F00D);
      term_and_run(32'hCAFE_F00D);
      total++;
      if (wa.size() != 3 || wa[0] !== 5'd0 || wd[0] !== 32'hAAAA_5555 || wa[1] !== 5'd0 || wd[1] !== 32'hCAFE_F00D
          || wa[2] !== 5'd1 || done_o !== 1'b1) begin
         bad++;
         $display("FAIL abort_log: got %0d writes done=%b, want 3 writes 0:aaaa5555 0:cafef00d 1:0 done=1",
                  wa.size(), done_o);
      end
   endtask

   task automatic test_full_fit();
      logic [31:0] sum = 32'h0;
      logic [31:0] w;
      clear_log();
      pulse_start();
      for (int i = 0; i < 31; i++) begin
         w = 32'h2000_0000 | i;
         sum += w;
         send_word(w);
      end
      term_and_run(sum);
      total++;
      if ({done_o, err_o, word_cnt_o} !== {2'b10, 6'd32} || wa.size() != 32 || wa[31] !== 5'd31 || wd[31] !== 32'h0) begin
         bad++;
         $display("FAIL full_fit: got done=%b err=%b cnt=%0d writes=%0d, want 1 0 32 32 with addr31=0",
                  done_o, err_o, word_cnt_o, wa.size());
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      clear_log();
      pulse_start();
      repeat (1100) @(negedge clk_i);
      total++;
      if ({err_o, busy_o, byte_ready_o} !== 3'b011) begin
         bad++;
         $display("FAIL timeout_prefirst: got err=%b busy=%b rdy=%b, want 0 1 1", err_o, busy_o, byte_ready_o);
      end
      send_byte(8'hAB);
      send_byte(8'hCD);
      while (err_o !== 1'b1 && n < 1100) begin
         @(negedge clk_i);
         n++;
      end
      total++;
      if (n != 1024) begin
         bad++;
         $display("FAIL timeout_cycles: got err after %0d idle cycles, want 1024", n);
      end
      total++;
      if ({cpu_rst_n_o, byte_ready_o, wa.size() == 0} !== 3'b001) begin
         bad++;
         $display("FAIL timeout_state: got cpu=%b rdy=%b writes=%0d, want 0 0 0", cpu_rst_n_o, byte_ready_o, wa.size());
      end
   endtask

   task automatic test_async_reset();
      pulse_start();
      send_word(32'h0000_0001);
      send_byte(8'h09);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({byte_ready_o, im_we_o, cpu_rst_n_o, busy_o, done_o, err_o, word_cnt_o} !== 12'h0) begin
         bad++;
         $display("FAIL async_reset: got rdy/we/cpu/busy/done/err=%b cnt=%0d, want 000000 0",
                  {byte_ready_o, im_we_o, cpu_rst_n_o, busy_o, done_o, err_o}, word_cnt_o);
      end
      @(negedge clk_i);
      rst_n = 1'b1;
      @(negedge clk_i);
      clear_log();
      pulse_start();
      send_word(32'h0000_0077);
      total++;
      if ({im_we_o, im_addr_o, im_wdata_o} !== {1'b1, 5'd0, 32'h77}) begin
         bad++;
         $display("FAIL post_reset_word: got we=%b addr=%0d data=%h, want 1 0 00000077", im_we_o, im_addr_o, im_wdata_o);
      end
      term_and_run(32'h77);
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      clear_log();
      pulse_start();
      send_word(32'h5);
      send_word(32'h0);
      send_word(32'h5);
      total++;
      if ({done_o, cpu_rst_n_o, err_o, chk_err_o} !== 4'b1100 || wa.size() != 2) begin
         bad++;
         $display("FAIL chk_good: got done=%b cpu=%b err=%b chk=%b writes=%0d, want 1 1 0 0 2",
                  done_o, cpu_rst_n_o, err_o, chk_err_o, wa.size());
      end
      clear_log();
      pulse_start();
      send_word(32'h5);
      send_word(32'h0);
      send_word(32'h6);
      total++;
      if ({done_o, cpu_rst_n_o, err_o, chk_err_o} !== 4'b0011 || wa.size() != 2) begin
         bad++;
         $display("FAIL chk_bad: got done=%b cpu=%b err=%b chk=%b writes=%0d, want 0 0 1 1 2",
                  done_o, cpu_rst_n_o, err_o, chk_err_o, wa.size());
      end
      pulse_start();
      total++;
      if ({err_o, chk_err_o} !== 2'b00) begin
         bad++;
         $display("FAIL chk_clear: got err=%b chk=%b, want 0 0", err_o, chk_err_o);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_normal();
      test_run_ignore();
      test_reload();
      test_gaps();
      test_overflow();
      test_abort();
      test_full_fit();
      test_timeout();
      test_async_reset();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
